// File: rtl/chess_pkg.sv
// Shared encodings for the chess clock game sequencer: FSM states and player ids.
package chess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN1  = 3'd3,
        ST_RUN2  = 3'd4,
        ST_PAUSE = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

endpackage

// File: rtl/chess_tick_div.sv
// Prescaler that turns the system clock into one wrap flag every TICK_DIV running cycles.
module chess_tick_div #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt;

    // tick marks the cycle in which the count wraps; the caller registers it.
    assign tick = run && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock game sequencer: loads budgets, alternates the running counter, handles pause and flag fall.
module chess_turn_ctrl
    import chess_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int TW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          btn1,
    input  logic          btn2,
    input  logic [TW-1:0] time_in,
    input  logic          fin,
    output logic          enload,
    output logic [TW-1:0] load_val,
    output logic          count1,
    output logic          count2,
    output logic          turn,
    output logic          game_over,
    output logic          loser,
    output logic [7:0]    moves
);

    state_t state, next_state;
    logic   start_q, pause_q, btn1_q, btn2_q;
    logic   start_e, pause_e, btn1_e, btn2_e;
    logic   clr, run, tick, switch_turn;

    assign start_e = start && !start_q;
    assign pause_e = pause && !pause_q;
    assign btn1_e  = btn1 && !btn1_q;
    assign btn2_e  = btn2 && !btn2_q;

    assign run         = (state == ST_RUN1) || (state == ST_RUN2);
    assign switch_turn = ((state == ST_RUN1) && (next_state == ST_RUN2)) ||
                         ((state == ST_RUN2) && (next_state == ST_RUN1));

    chess_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            btn1_q  <= 1'b0;
            btn2_q  <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start;
            pause_q <= pause;
            btn1_q  <= btn1;
            btn2_q  <= btn2;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: if (start_e) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_READY;
            ST_READY: if (btn2_e) begin
                next_state = ST_RUN1;
                clr        = 1'b1;
            end
            ST_RUN1: begin
                if (fin)          next_state = ST_OVER;
                else if (pause_e) next_state = ST_PAUSE;
                else if (btn1_e) begin
                    next_state = ST_RUN2;
                    clr        = 1'b1;
                end
            end
            ST_RUN2: begin
                if (fin)          next_state = ST_OVER;
                else if (pause_e) next_state = ST_PAUSE;
                else if (btn2_e) begin
                    next_state = ST_RUN1;
                    clr        = 1'b1;
                end
            end
            ST_PAUSE: if (pause_e) next_state = (turn == P2) ? ST_RUN2 : ST_RUN1;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the transition being taken, so they line up with the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            enload    <= 1'b0;
            load_val  <= '0;
            count1    <= 1'b0;
            count2    <= 1'b0;
            turn      <= P1;
            game_over <= 1'b0;
            loser     <= P1;
            moves     <= 8'd0;
        end else begin
            enload <= (next_state == ST_LOAD);
            // A wrap only becomes a pulse if the same player is still running next cycle.
            count1 <= tick && (state == ST_RUN1) && (next_state == ST_RUN1);
            count2 <= tick && (state == ST_RUN2) && (next_state == ST_RUN2);
            if (next_state == ST_LOAD) begin
                load_val  <= time_in;
                moves     <= 8'd0;
                game_over <= 1'b0;
                loser     <= P1;
                turn      <= P1;
            end
            if (run && (next_state == ST_OVER)) begin
                game_over <= 1'b1;
                loser     <= (state == ST_RUN2) ? P2 : P1;
            end
            if (switch_turn) begin
                turn <= ~turn;
                if (moves != 8'd255) moves <= moves + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Self-checking bench for chess_turn_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_chess_turn_ctrl;

    localparam int TD = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset, start, pause, btn1, btn2, fin;
    logic [TW-1:0] time_in;
    logic          enload, count1, count2, turn, game_over, loser;
    logic [TW-1:0] load_val;
    logic [7:0]    moves;

    int total = 0;
    int bad   = 0;

    chess_turn_ctrl #(.TICK_DIV(TD), .TW(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .btn1      (btn1),
        .btn2      (btn2),
        .time_in   (time_in),
        .fin       (fin),
        .enload    (enload),
        .load_val  (load_val),
        .count1    (count1),
        .count2    (count2),
        .turn      (turn),
        .game_over (game_over),
        .loser     (loser),
        .moves     (moves)
    );

    always #5 clk = ~clk;

    // Behavioural model: one "running" phase plus whose clock is running, elapsed-cycle arithmetic.
    typedef enum {PH_IDLE, PH_LOAD, PH_READY, PH_RUN, PH_PAUSED, PH_OVER} phase_t;
    phase_t        m_phase;
    bit            m_enload, m_c1, m_c2, m_turn, m_over, m_loser;
    logic [TW-1:0] m_load_val;
    int            m_moves, m_elapsed;
    bit            p_start, p_pause, p_btn1, p_btn2;

    task automatic model_new_game();
        m_phase    = PH_LOAD;
        m_enload   = 1'b1;
        m_load_val = time_in;
        m_moves    = 0;
        m_over     = 1'b0;
        m_loser    = 1'b0;
        m_turn     = 1'b0;
    endtask

    task automatic model_update();
        bit se, pe, b1e, b2e, own;
        se  = start && !p_start;
        pe  = pause && !p_pause;
        b1e = btn1 && !p_btn1;
        b2e = btn2 && !p_btn2;
        if (reset) begin
            m_phase = PH_IDLE; m_enload = 0; m_load_val = '0; m_c1 = 0; m_c2 = 0;
            m_turn = 0; m_over = 0; m_loser = 0; m_moves = 0; m_elapsed = 0;
            p_start = 0; p_pause = 0; p_btn1 = 0; p_btn2 = 0;
        end else begin
            m_enload = 0; m_c1 = 0; m_c2 = 0;
            own = m_turn ? b2e : b1e;
            case (m_phase)
                PH_IDLE, PH_OVER: if (se) model_new_game();
                PH_LOAD:   m_phase = PH_READY;
                PH_READY:  if (b2e) begin m_phase = PH_RUN; m_turn = 0; m_elapsed = 0; end
                PH_RUN: begin
                    if (fin) begin
                        m_phase = PH_OVER; m_over = 1; m_loser = m_turn;
                    end else if (pe) begin
                        m_elapsed++; m_phase = PH_PAUSED;
                    end else if (own) begin
                        m_turn = !m_turn; m_elapsed = 0;
                        if (m_moves < 255) m_moves++;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed % TD == 0) begin
                            if (m_turn) m_c2 = 1; else m_c1 = 1;
                        end
                    end
                end
                PH_PAUSED: if (pe) m_phase = PH_RUN;
                default:   m_phase = PH_IDLE;
            endcase
            p_start = start; p_pause = pause; p_btn1 = btn1; p_btn2 = btn2;
        end
    endtask

    // Advance one clock, update the model with the inputs sampled at that edge, land on the negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; start = 0; pause = 0; btn1 = 0; btn2 = 0; fin = 0; time_in = '0;
        step(); step();
        reset = 0;
        total++;
        if ({enload, load_val, count1, count2, turn, game_over, loser, moves} !== '0) begin
            bad++;
            $display("FAIL reset_values got=%h want=0",
                     {enload, load_val, count1, count2, turn, game_over, loser, moves});
        end
        for (int i = 0; i < 8; i++) begin
            btn1 = (i == 1); btn2 = (i == 3); pause = (i == 5);
            step();
            total++;
            if ({enload, count1, count2, turn, moves} !== '0) begin
                bad++;
                $display("FAIL idle_ignores_inputs i=%0d enload=%b c1=%b c2=%b turn=%b moves=%0d want all 0",
                         i, enload, count1, count2, turn, moves);
            end
        end
        btn1 = 0; btn2 = 0; pause = 0;
    endtask

    task automatic test_load();
        time_in = 8'd3; start = 1;
        step();
        start = 0;
        total++;
        if (enload !== 1'b1 || load_val !== 8'd3 || game_over !== 1'b0 || moves !== 8'd0) begin
            bad++;
            $display("FAIL load_strobe enload=%b load_val=%0d game_over=%b moves=%0d want 1/3/0/0",
                     enload, load_val, game_over, moves);
        end
        step();
        total++;
        if (enload !== 1'b0 || load_val !== 8'd3) begin
            bad++;
            $display("FAIL load_one_cycle enload=%b load_val=%0d want 0/3", enload, load_val);
        end
        // READY ignores btn1 and pause
        btn1 = 1; pause = 1; step(); btn1 = 0; pause = 0; step(); step();
        total++;
        if (turn !== 1'b0 || moves !== 8'd0 || count1 !== 1'b0 || count2 !== 1'b0) begin
            bad++;
            $display("FAIL ready_ignores turn=%b moves=%0d c1=%b c2=%b want 0", turn, moves, count1, count2);
        end
    endtask

    task automatic test_turn_switch();
        btn2 = 1; step(); btn2 = 0;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (count1 !== ((k > 0) && (k % TD == 0)) || count2 !== 1'b0) begin
                bad++;
                $display("FAIL run1_pulses k=%0d c1=%b c2=%b want c1=%b c2=0",
                         k, count1, count2, (k > 0) && (k % TD == 0));
            end
            if (k == 15) btn1 = 1;
            step();
        end
        btn1 = 0;
        total++;
        if (turn !== 1'b1 || moves !== 8'd1 || count1 !== 1'b0) begin
            bad++;
            $display("FAIL switch_to_p2 turn=%b moves=%0d c1=%b want 1/1/0", turn, moves, count1);
        end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (count2 !== ((k > 0) && (k % TD == 0)) || count1 !== 1'b0) begin
                bad++;
                $display("FAIL run2_pulses k=%0d c1=%b c2=%b want c1=0 c2=%b",
                         k, count1, count2, (k > 0) && (k % TD == 0));
            end
            step();
        end
    endtask

    task automatic test_pause_resume();
        btn2 = 1; step(); btn2 = 0;
        btn1 = 1; step(); btn1 = 0;
        step();
        pause = 1; step(); pause = 0;
        for (int i = 0; i < 20; i++) begin
            btn2 = (i == 5); fin = (i == 10);
            total++;
            if (count1 !== 1'b0 || count2 !== 1'b0) begin
                bad++;
                $display("FAIL paused_no_pulse i=%0d c1=%b c2=%b want 0/0", i, count1, count2);
            end
            step();
        end
        btn2 = 0; fin = 0;
        total++;
        if (turn !== 1'b1 || game_over !== 1'b0 || moves !== 8'd3) begin
            bad++;
            $display("FAIL paused_ignores turn=%b game_over=%b moves=%0d want 1/0/3", turn, game_over, moves);
        end
        pause = 1; step(); pause = 0;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (count2 !== ((k == 2) || (k == 6)) || count1 !== 1'b0) begin
                bad++;
                $display("FAIL resume_pulse k=%0d c1=%b c2=%b want c1=0 c2=%b", k, count1, count2,
                         (k == 2) || (k == 6));
            end
            step();
        end
    endtask

    task automatic test_flag_fall();
        fin = 1; step(); fin = 0;
        total++;
        if (game_over !== 1'b1 || loser !== 1'b1) begin
            bad++;
            $display("FAIL flag_fall game_over=%b loser=%b want 1/1", game_over, loser);
        end
        for (int i = 0; i < 10; i++) begin
            btn1 = (i == 2); btn2 = (i == 4); pause = (i == 6);
            step();
            total++;
            if (count1 !== 1'b0 || count2 !== 1'b0 || game_over !== 1'b1 || loser !== 1'b1) begin
                bad++;
                $display("FAIL over_hold i=%0d c1=%b c2=%b go=%b loser=%b want 0/0/1/1",
                         i, count1, count2, game_over, loser);
            end
        end
        btn1 = 0; btn2 = 0; pause = 0;
        time_in = 8'd77; start = 1; step(); start = 0;
        total++;
        if (enload !== 1'b1 || load_val !== 8'd77 || game_over !== 1'b0 || loser !== 1'b0 ||
            moves !== 8'd0 || turn !== 1'b0) begin
            bad++;
            $display("FAIL reload enload=%b load_val=%0d go=%b loser=%b moves=%0d turn=%b want 1/77/0/0/0/0",
                     enload, load_val, game_over, loser, moves, turn);
        end
        step();
    endtask

    task automatic test_priority();
        btn2 = 1; step(); btn2 = 0; step(); step();
        fin = 1; pause = 1; btn1 = 1; step(); fin = 0; pause = 0; btn1 = 0;
        total++;
        if (game_over !== 1'b1 || loser !== 1'b0 || moves !== 8'd0 || turn !== 1'b0) begin
            bad++;
            $display("FAIL prio_fin go=%b loser=%b moves=%0d turn=%b want 1/0/0/0", game_over, loser, moves, turn);
        end
        start = 1; step(); start = 0; step();
        btn2 = 1; step(); btn2 = 0; step();
        pause = 1; btn1 = 1; step(); pause = 0; btn1 = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (turn !== 1'b0 || moves !== 8'd0 || count1 !== 1'b0 || game_over !== 1'b0) begin
                bad++;
                $display("FAIL prio_pause i=%0d turn=%b moves=%0d c1=%b go=%b want 0/0/0/0",
                         i, turn, moves, count1, game_over);
            end
            step();
        end
        pause = 1; step(); pause = 0;
    endtask

    task automatic test_reset_midgame();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) btn1 = 1; else btn2 = 1;
            step(); btn1 = 0; btn2 = 0; step();
        end
        total++;
        if (moves !== 8'd5 || turn !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset moves=%0d turn=%b want 5/1", moves, turn);
        end
        reset = 1; step(); reset = 0;
        total++;
        if ({enload, load_val, count1, count2, turn, game_over, loser, moves} !== '0) begin
            bad++;
            $display("FAIL midgame_reset got=%h want=0",
                     {enload, load_val, count1, count2, turn, game_over, loser, moves});
        end
        for (int i = 0; i < 10; i++) begin
            btn2 = (i == 1); btn1 = (i == 4); pause = (i == 7);
            step();
            total++;
            if ({enload, count1, count2, turn, moves} !== '0) begin
                bad++;
                $display("FAIL after_reset_idle i=%0d enload=%b c1=%b c2=%b turn=%b moves=%0d want 0",
                         i, enload, count1, count2, turn, moves);
            end
        end
        btn1 = 0; btn2 = 0; pause = 0;
        time_in = 8'd200; start = 1; step(); start = 0;
        total++;
        if (enload !== 1'b1 || load_val !== 8'd200) begin
            bad++;
            $display("FAIL restart enload=%b load_val=%0d want 1/200", enload, load_val);
        end
        step();
    endtask

    task automatic test_saturation();
        btn2 = 1; step(); btn2 = 0;
        for (int i = 1; i <= 260; i++) begin
            if (i % 2 == 1) btn1 = 1; else btn2 = 1;
            step(); btn1 = 0; btn2 = 0;
            if (i == 254 || i == 260) begin
                total++;
                if (moves !== ((i == 254) ? 8'd254 : 8'd255) || turn !== 1'b0) begin
                    bad++;
                    $display("FAIL moves_saturate i=%0d moves=%0d turn=%b want %0d/0",
                             i, moves, turn, (i == 254) ? 254 : 255);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [21:0] got, exp;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) start = !start;
            if ($urandom_range(0, 19) == 0) pause = !pause;
            btn1    = ($urandom_range(0, 5) == 0);
            btn2    = ($urandom_range(0, 5) == 0);
            fin     = ($urandom_range(0, 199) == 0);
            time_in = TW'($urandom);
            step();
            got = {enload, load_val, count1, count2, turn, game_over, loser, moves};
            exp = {m_enload, m_load_val, m_c1, m_c2, m_turn, m_over, m_loser, 8'(m_moves)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", i, got, exp);
            end
            total++;
            if ((count1 && count2) || (enload && (count1 || count2))) begin
                bad++;
                $display("FAIL random_invariant cyc=%0d enload=%b c1=%b c2=%b want exclusive",
                         i, enload, count1, count2);
            end
        end
        reset = 0; start = 0; pause = 0; btn1 = 0; btn2 = 0; fin = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_turn_switch();
        test_pause_resume();
        test_flag_fall();
        test_priority();
        test_reset_midgame();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
